snitch_mem_initiator: RTL
=========================

SNITCH_MEM_INITIATOR -- requirements
Module: snitch_mem_initiator

Interface
REQ-001 Parameter AddrWidth, default 10, word address width of the request channel.
REQ-002 Parameter DataWidth, default 32, data width of the request and response channels.
REQ-003 Parameter TimeoutCycles, default 64, read-response wait limit in cycles (>=2).
REQ-004 Port list (name  direction  width  meaning):
- clk_i  in  1  sole clock; all logic rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  core command valid.
- cmd_ready_o  out  1  command accepted.
- cmd_write_i  in  1  1 = store, 0 = load.
- cmd_addr_i  in  AddrWidth  word address.
- cmd_wdata_i  in  DataWidth  store data.
- cmd_wstrb_i  in  1  store strobe.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_data_o  out  DataWidth  load data (0 for stores and timeouts).
- res_err_o  out  1  result is a timeout.
- req_addr_o  out  AddrWidth  memory request address.
- req_data_o  out  DataWidth  memory write data.
- req_write_o  out  1  memory write flag.
- req_wstrb_o  out  1  memory write strobe.
- req_valid_o  out  1  memory request valid.
- req_ready_i  in  1  memory request accepted.
- rsp_data_i  in  DataWidth  memory read data.
- rsp_valid_i  in  1  memory response valid.
- rsp_ready_o  out  1  memory response accepted.
- busy_o  out  1  high in any state other than IDLE.
- timeout_sticky_o  out  1  set by any timeout; cleared only by reset.

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT_RSP, RESULT; one transaction in flight at most.
REQ-006 IDLE: cmd_ready_o=1; on cmd_valid_i, command fields SHALL be registered and state SHALL go to REQ the next cycle.
REQ-007 REQ: req_valid_o=1 with req_* driven from the registered command; all req_* SHALL hold stable until req_ready_i is sampled high.
REQ-008 REQ with req_ready_i=1 and write: state SHALL go to RESULT with res_data=0, res_err=0.
REQ-009 REQ with req_ready_i=1 and read: state SHALL go to WAIT_RSP and clear the timeout counter.
REQ-010 WAIT_RSP: rsp_ready_o=1; on rsp_valid_i, rsp_data_i SHALL be captured, res_err=0, state SHALL go to RESULT.
REQ-011 WAIT_RSP: counter SHALL increment each cycle without rsp_valid_i; at count TimeoutCycles-1 without response, state SHALL go to RESULT with res_data=0, res_err=1, timeout_sticky_o set.
REQ-012 Response and timeout in the same cycle: the response SHALL win (res_err=0).
REQ-013 RESULT: res_valid_o=1 with data/err held stable; on res_ready_i, state SHALL go to IDLE.
REQ-014 rsp_ready_o SHALL be 0 outside WAIT_RSP; rsp_valid_i outside WAIT_RSP SHALL be ignored.
REQ-015 cmd_ready_o SHALL be 0 outside IDLE; no command bypass; minimum latency is command handshake at cycle N, req_valid_o at N+1, read result at N+3 with a zero-wait memory.
REQ-016 Counter width SHALL be $clog2(TimeoutCycles) bits and SHALL not wrap within a transaction.

Reset
REQ-017 While rst_i is high at a clock edge: state=IDLE; all req_*, res_*, rsp_ready_o, busy_o, timeout_sticky_o, counter, and registered command SHALL be 0; cmd_ready_o SHALL be 1 from the first cycle after reset deasserts.
REQ-018 Reset asserted mid-transaction SHALL abandon it without emitting a result.

Structure
REQ-019 Package snitch_mem_pkg SHALL hold addr_t, data_t, the FSM state enum, and default parameter constants.
REQ-020 Flat single module; no sub-module.

Verification
REQ-021 Read, memory returns 0x00000517 one cycle after request: cmd read addr 0x000 -> req_valid_o one cycle, res_valid_o with res_data_o=0x00000517, res_err_o=0.
REQ-022 Write, req_ready_i low 3 cycles: cmd write addr 0x3FF data 0xCAFEF00D -> req_* stable for 4 cycles, result data 0, err 0.
REQ-023 Read, no response: TimeoutCycles=8 -> RESULT exactly 8 cycles after entering WAIT_RSP, res_err_o=1, timeout_sticky_o=1.
REQ-024 Result backpressure: res_ready_i low 5 cycles -> res_valid_o/res_data_o stable, cmd_ready_o=0 throughout.
REQ-025 Reset in WAIT_RSP, and stray rsp_valid_i in IDLE -> all outputs 0 next cycle, no result emitted, stray response not accepted (rsp_ready_o=0).

Source files
------------

// File: rtl/snitch_mem_pkg.sv
// Shared types and defaults for the snitch memory initiator.
// One command in flight: IDLE -> REQ -> (WAIT_RSP) -> RESULT.
package snitch_mem_pkg;
    localparam int unsigned DefAddrWidth     = 10;
    localparam int unsigned DefDataWidth     = 32;
    localparam int unsigned DefTimeoutCycles = 64;

    typedef logic [DefAddrWidth-1:0] addr_t;
    typedef logic [DefDataWidth-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        RESULT
    } state_e;
endpackage

// File: rtl/snitch_mem_initiator_if.sv
// Memory-side request/response channel bundle.
// The initiator drives the master view and the memory uses the slave view.
interface snitch_mem_initiator_if #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 32
) (
    input logic clk_i
);
    logic [AddrWidth-1:0] req_addr;
    logic [DataWidth-1:0] req_data;
    logic                 req_write;
    logic                 req_wstrb;
    logic                 req_valid;
    logic                 req_ready;
    logic [DataWidth-1:0] rsp_data;
    logic                 rsp_valid;
    logic                 rsp_ready;

    modport master (
        input  clk_i,
        output req_addr, req_data, req_write, req_wstrb, req_valid,
        input  req_ready,
        input  rsp_data, rsp_valid,
        output rsp_ready
    );

    modport slave (
        input  clk_i,
        input  req_addr, req_data, req_write, req_wstrb, req_valid,
        output req_ready,
        output rsp_data, rsp_valid,
        input  rsp_ready
    );
endinterface

// File: rtl/snitch_mem_initiator.sv
// Single-outstanding memory initiator bridging a core command port to memory.
// Reads wait a bounded number of cycles for a response before reporting an error.
module snitch_mem_initiator
    import snitch_mem_pkg::*;
#(
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned DataWidth     = DefDataWidth,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    input  logic                 cmd_wstrb_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [DataWidth-1:0] res_data_o,
    output logic                 res_err_o,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [DataWidth-1:0] req_data_o,
    output logic                 req_write_o,
    output logic                 req_wstrb_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic [DataWidth-1:0] rsp_data_i,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    output logic                 busy_o,
    output logic                 timeout_sticky_o
);
    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    state_e               state_q, state_d;
    logic                 wr_q, wr_d;
    logic                 wstrb_q, wstrb_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            wstrb_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = REQ;
                    wr_d    = cmd_write_i;
                    wstrb_d = cmd_wstrb_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                end
            end
            REQ: begin
                if (req_ready_i) begin
                    if (wr_q) begin
                        state_d = RESULT;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = WAIT_RSP;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_RSP: begin
                // A response arriving on the last counted cycle still wins.
                if (rsp_valid_i) begin
                    state_d = RESULT;
                    rdata_d = rsp_data_i;
                    err_d   = 1'b0;
                end else if (cnt_q == CntLast) begin
                    state_d  = RESULT;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            RESULT: begin
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by state so that idle or reset leaves the bus at zero.
    assign cmd_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign req_valid_o      = (state_q == REQ);
    assign req_addr_o       = req_valid_o ? addr_q : '0;
    assign req_data_o       = req_valid_o ? wdata_q : '0;
    assign req_write_o      = req_valid_o & wr_q;
    assign req_wstrb_o      = req_valid_o & wstrb_q;
    assign rsp_ready_o      = (state_q == WAIT_RSP);
    assign res_valid_o      = (state_q == RESULT);
    assign res_data_o       = res_valid_o ? rdata_q : '0;
    assign res_err_o        = res_valid_o & err_q;
    assign timeout_sticky_o = sticky_q;
endmodule
